// File: rtl/gpu_pkg.sv
// Shared types and defaults for the GPU raster-path blocks.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } rect_state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  localparam int GPU_SCREEN_W = 640;
  localparam int GPU_SCREEN_H = 480;

endpackage

// File: rtl/gpu_rect_clip.sv
// Combinational corner normalisation and clip of a rectangle to the visible screen.
module gpu_rect_clip
  import gpu_pkg::*;
#(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int SCREEN_W    = GPU_SCREEN_W,
  parameter int SCREEN_H    = GPU_SCREEN_H
) (
  input  logic [WIDTH_BITS-1:0]  x1,
  input  logic [WIDTH_BITS-1:0]  x2,
  input  logic [HEIGHT_BITS-1:0] y1,
  input  logic [HEIGHT_BITS-1:0] y2,
  output logic [WIDTH_BITS-1:0]  xmin,
  output logic [WIDTH_BITS-1:0]  xmax,
  output logic [HEIGHT_BITS-1:0] ymin,
  output logic [HEIGHT_BITS-1:0] ymax,
  output logic                   offscreen
);

  localparam logic [WIDTH_BITS-1:0]  X_LAST = WIDTH_BITS'(SCREEN_W - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_LAST = HEIGHT_BITS'(SCREEN_H - 1);

  logic [WIDTH_BITS-1:0]  x_hi;
  logic [HEIGHT_BITS-1:0] y_hi;

  always_comb begin
    xmin = (x1 <= x2) ? x1 : x2;
    x_hi = (x1 <= x2) ? x2 : x1;
    ymin = (y1 <= y2) ? y1 : y2;
    y_hi = (y1 <= y2) ? y2 : y1;
    // Only the far edges need clipping; a near edge past the screen means nothing is visible.
    xmax = (32'(x_hi) > SCREEN_W - 1) ? X_LAST : x_hi;
    ymax = (32'(y_hi) > SCREEN_H - 1) ? Y_LAST : y_hi;
    offscreen = (32'(xmin) >= SCREEN_W) || (32'(ymin) >= SCREEN_H);
  end

endmodule

// File: rtl/gpu_rect_gen.sv
// Rectangle pixel walker: emits clipped fill/outline pixels in raster order over valid/ready.
module gpu_rect_gen
  import gpu_pkg::*;
#(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int SCREEN_W     = GPU_SCREEN_W,
  parameter int SCREEN_H     = GPU_SCREEN_H,
  parameter int CHANNEL_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic                    mode_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    abort_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [WIDTH_BITS-1:0]   x_o,
  output logic [HEIGHT_BITS-1:0]  y_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    busy_o,
  output logic                    done_o
);

  // Handshake: a pixel transfers on a rising clk edge where valid_o && ready_i;
  // while valid_o is high and ready_i low, x_o/y_o/colour stay unchanged.

  rect_state_t state_q, state_d;

  logic [WIDTH_BITS-1:0]   x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [HEIGHT_BITS-1:0]  y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic                    mode_q, mode_d;
  logic [CHANNEL_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic [WIDTH_BITS-1:0]   c_xmin, c_xmax;
  logic [HEIGHT_BITS-1:0]  c_ymin, c_ymax;
  logic                    c_off;
  logic                    interior_row;

  gpu_rect_clip #(
    .WIDTH_BITS (WIDTH_BITS),
    .HEIGHT_BITS(HEIGHT_BITS),
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H)
  ) u_clip (
    .x1       (x1_i),
    .x2       (x2_i),
    .y1       (y1_i),
    .y2       (y2_i),
    .xmin     (c_xmin),
    .xmax     (c_xmax),
    .ymin     (c_ymin),
    .ymax     (c_ymax),
    .offscreen(c_off)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      mode_q  <= MODE_FILL;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign interior_row = (y_q != ymin_q) && (y_q != ymax_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    mode_d  = mode_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          xmin_d  = c_xmin;
          xmax_d  = c_xmax;
          ymin_d  = c_ymin;
          ymax_d  = c_ymax;
          mode_d  = mode_i;
          r_d     = r_i;
          g_d     = g_i;
          b_d     = b_i;
          x_d     = c_xmin;
          y_d     = c_ymin;
          state_d = c_off ? DONE : EMIT;
        end
      end
      EMIT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (ready_i) begin
          if ((x_q == xmax_q) && (y_q == ymax_q)) begin
            state_d = DONE;
          end else if (x_q == xmax_q) begin
            x_d = xmin_q;
            y_d = y_q + HEIGHT_BITS'(1);
          end else if ((mode_q == MODE_OUTLINE) && interior_row && (x_q == xmin_q)) begin
            // Interior outline rows only carry the two side pixels.
            x_d = xmax_q;
          end else begin
            x_d = x_q + WIDTH_BITS'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign valid_o = (state_q == EMIT);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign r_o     = r_q;
  assign g_o     = g_q;
  assign b_o     = b_q;

endmodule

// File: tb/tb_gpu_rect_gen.sv
// Directed bench for gpu_rect_gen: expected pixels queued at issue, checked by a monitor on transfer.
module tb_gpu_rect_gen;
  import gpu_pkg::*;

  localparam int WB = 10;
  localparam int HB = 9;
  localparam int CB = 8;
  localparam int PW = WB + HB + 3 * CB;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start_i = 1'b0;
  logic [WB-1:0] x1_i = '0, x2_i = '0;
  logic [HB-1:0] y1_i = '0, y2_i = '0;
  logic          mode_i = 1'b0;
  logic [CB-1:0] r_i = '0, g_i = '0, b_i = '0;
  logic          abort_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          valid_o;
  logic [WB-1:0] x_o;
  logic [HB-1:0] y_o;
  logic [CB-1:0] r_o, g_o, b_o;
  logic          busy_o, done_o;

  gpu_rect_gen dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .start_i(start_i),
    .x1_i   (x1_i),
    .x2_i   (x2_i),
    .y1_i   (y1_i),
    .y2_i   (y2_i),
    .mode_i (mode_i),
    .r_i    (r_i),
    .g_i    (g_i),
    .b_i    (b_i),
    .abort_i(abort_i),
    .ready_i(ready_i),
    .valid_o(valid_o),
    .x_o    (x_o),
    .y_o    (y_o),
    .r_o    (r_o),
    .g_o    (g_o),
    .b_o    (b_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mon_exp, mon_act;
  int checks = 0, errors = 0;
  int done_cnt = 0, xfer_cnt = 0, last_xfer_cyc = 0, done_cyc = 0, s_cyc = 0;
  logic [CB-1:0] cur_r = '0, cur_g = '0, cur_b = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (valid_o && ready_i) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        checks++;
        mon_act = {x_o, y_o, r_o, g_o, b_o};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d, expected no pixel", x_o, y_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL pixel: got x=%0d y=%0d rgb=%h, expected x=%0d y=%0d rgb=%h",
                     x_o, y_o, mon_act[3*CB-1:0], mon_exp[PW-1 -: WB],
                     mon_exp[3*CB+HB-1 -: HB], mon_exp[3*CB-1:0]);
          end
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic push_px(input int x, input int y);
    exp_q.push_back({WB'(x), HB'(y), cur_r, cur_g, cur_b});
  endtask

  task automatic set_colour(input logic [CB-1:0] r, input logic [CB-1:0] g, input logic [CB-1:0] b);
    cur_r = r;
    cur_g = g;
    cur_b = b;
  endtask

  // Leaves the caller one cycle after the start cycle.
  task automatic start_cmd(input int xa, input int ya, input int xb, input int yb, input logic mode);
    @(posedge clk); #1;
    x1_i = WB'(xa); y1_i = HB'(ya);
    x2_i = WB'(xb); y2_i = HB'(yb);
    mode_i = mode;
    r_i = cur_r; g_i = cur_g; b_i = cur_b;
    start_i = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle_timeout"}, 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  int done_base, xfer_base;

  initial begin
    // reset state
    #1;
    check("rst_valid", 64'(valid_o), 0);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_done", 64'(done_o), 0);
    check("rst_xy", 64'({x_o, y_o}), 0);
    check("rst_rgb", 64'({r_o, g_o, b_o}), 0);
    #20 n_rst = 1'b1;
    ready_i = 1'b1;

    // fill (2,3)-(4,4)
    set_colour(8'h11, 8'h22, 8'h33);
    push_px(2, 3); push_px(3, 3); push_px(4, 3);
    push_px(2, 4); push_px(3, 4); push_px(4, 4);
    done_base = done_cnt;
    start_cmd(2, 3, 4, 4, MODE_FILL);
    check("fill_latency_valid", 64'(valid_o), 1);
    check("fill_busy", 64'(busy_o), 1);
    wait_idle("fill");
    check("fill_done_count", 64'(done_cnt - done_base), 1);
    check("fill_done_after_last", 64'(done_cyc), 64'(last_xfer_cyc + 1));

    // swapped corners, outline, h=2
    set_colour(8'hA0, 8'hB1, 8'hC2);
    push_px(2, 3); push_px(3, 3); push_px(4, 3);
    push_px(2, 4); push_px(3, 4); push_px(4, 4);
    done_base = done_cnt;
    start_cmd(4, 4, 2, 3, MODE_OUTLINE);
    wait_idle("outline_h2");
    check("outline_h2_done", 64'(done_cnt - done_base), 1);

    // outline 4x4 -> 12 pixels
    set_colour(8'h01, 8'h02, 8'h03);
    for (int x = 10; x <= 13; x++) push_px(x, 10);
    push_px(10, 11); push_px(13, 11);
    push_px(10, 12); push_px(13, 12);
    for (int x = 10; x <= 13; x++) push_px(x, 13);
    xfer_base = xfer_cnt;
    start_cmd(10, 10, 13, 13, MODE_OUTLINE);
    wait_idle("outline_4x4");
    check("outline_4x4_count", 64'(xfer_cnt - xfer_base), 12);

    // backpressure
    set_colour(8'h55, 8'h66, 8'h77);
    ready_i = 1'b0;
    push_px(0, 0); push_px(1, 0);
    xfer_base = xfer_cnt;
    start_cmd(0, 0, 1, 0, MODE_FILL);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid_held", 64'(valid_o), 1);
      check("bp_xy_held", 64'({x_o, y_o}), 0);
      @(posedge clk); #1;
    end
    check("bp_no_xfer", 64'(xfer_cnt - xfer_base), 0);
    ready_i = 1'b1;
    wait_idle("bp");
    check("bp_count", 64'(xfer_cnt - xfer_base), 2);

    // clipping to 639,479
    set_colour(8'hFF, 8'h00, 8'h80);
    for (int y = 470; y <= 479; y++)
      for (int x = 630; x <= 639; x++) push_px(x, y);
    xfer_base = xfer_cnt;
    start_cmd(630, 470, 700, 500, MODE_FILL);
    wait_idle("clip");
    check("clip_count", 64'(xfer_cnt - xfer_base), 100);

    // fully off screen
    set_colour(8'h12, 8'h34, 8'h56);
    done_base = done_cnt;
    xfer_base = xfer_cnt;
    start_cmd(650, 0, 700, 5, MODE_FILL);
    check("off_no_valid", 64'(valid_o), 0);
    wait_idle("off");
    check("off_no_xfer", 64'(xfer_cnt - xfer_base), 0);
    check("off_done_count", 64'(done_cnt - done_base), 1);
    check("off_done_cycle", 64'(done_cyc), 64'(s_cyc + 1));

    // abort coinciding with third transfer of a 4x4 fill
    set_colour(8'h21, 8'h43, 8'h65);
    push_px(0, 0); push_px(1, 0); push_px(2, 0);
    done_base = done_cnt;
    xfer_base = xfer_cnt;
    start_cmd(0, 0, 3, 3, MODE_FILL);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_valid", 64'(valid_o), 0);
    check("abort_busy", 64'(busy_o), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_xfers", 64'(xfer_cnt - xfer_base), 3);
    check("abort_no_done", 64'(done_cnt - done_base), 0);
    check("abort_queue_empty", 64'(exp_q.size()), 0);

    // normal command after abort
    set_colour(8'h9A, 8'hBC, 8'hDE);
    push_px(5, 7); push_px(6, 7);
    done_base = done_cnt;
    start_cmd(6, 7, 5, 7, MODE_FILL);
    wait_idle("post_abort");
    check("post_abort_done", 64'(done_cnt - done_base), 1);

    // start while busy is ignored
    set_colour(8'h0F, 8'hF0, 8'h3C);
    for (int y = 0; y <= 1; y++)
      for (int x = 0; x <= 2; x++) push_px(x, y);
    xfer_base = xfer_cnt;
    done_base = done_cnt;
    start_cmd(0, 0, 2, 1, MODE_FILL);
    @(posedge clk); #1;
    x1_i = 10'd100; x2_i = 10'd200; y1_i = 9'd100; y2_i = 9'd200;
    r_i = 8'h00; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_idle("mid_start");
    check("mid_start_count", 64'(xfer_cnt - xfer_base), 6);
    check("mid_start_done", 64'(done_cnt - done_base), 1);

    // async reset mid-EMIT
    set_colour(8'h77, 8'h88, 8'h99);
    push_px(0, 0);
    done_base = done_cnt;
    start_cmd(0, 0, 3, 3, MODE_FILL);
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    check("arst_valid", 64'(valid_o), 0);
    check("arst_busy", 64'(busy_o), 0);
    check("arst_xy", 64'({x_o, y_o}), 0);
    check("arst_rgb", 64'({r_o, g_o, b_o}), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_queue_empty", 64'(exp_q.size()), 0);
    check("arst_no_done", 64'(done_cnt - done_base), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
